// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus bundle.
// Carries the hazard/redirect controls, the instruction-memory port and the
// IF/ID pipeline register outputs.
// Optional macro IF_PERF_CNT_EN adds fetch_cnt/bubble_cnt.
interface if_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_inst;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc_plus4;
  logic [DATA_W-1:0] id_inst;
  logic              id_valid;
  logic              halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0]       fetch_cnt;
  logic [31:0]       bubble_cnt;
`endif

  // Fetch-stage side.
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_inst,
    output imem_addr, id_pc, id_pc_plus4, id_inst, id_valid, halted
`ifdef IF_PERF_CNT_EN
    , output fetch_cnt, bubble_cnt
`endif
  );

  // Environment side: hazard unit, branch resolution, imem, decode.
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_inst,
    input  imem_addr, id_pc, id_pc_plus4, id_inst, id_valid, halted
`ifdef IF_PERF_CNT_EN
    , input fetch_cnt, bubble_cnt
`endif
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage.
// Owns the PC, drives the combinational imem address and loads the IF/ID
// register. Redirect beats stall beats normal fetch; a HALT_INST word parks
// fetch until a redirect.
// Optional macro IF_PERF_CNT_EN adds fetch/bubble counters.
module if_stage #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_INST = DATA_W'(32'hFC00_0000),
  parameter logic [DATA_W-1:0] NOP_INST  = '0
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [ADDR_W-1:0] id_pc_q, id_pc_plus4_q;
  logic [DATA_W-1:0] id_inst_q;
  logic              id_valid_q;
  logic              do_load;
  logic              do_bubble;
  logic [ADDR_W-1:0] redirect_aligned;
  logic [ADDR_W-1:0] pc_plus4;
  logic [1:0]        unused_redirect_lo;

  assign redirect_aligned   = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lo = bus.redirect_pc[1:0];
  assign pc_plus4           = pc_q + ADDR_W'(4);

  // Next state, next PC and which IF/ID update (load, bubble or hold).
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    do_load   = 1'b0;
    do_bubble = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
        do_bubble = 1'b1;
        if (bus.redirect_valid) pc_nxt = redirect_aligned;
      end
      RUN, HALT: begin
        if (bus.redirect_valid) begin
          state_nxt = RUN;
          pc_nxt    = redirect_aligned;
          do_bubble = 1'b1;
        end else if (bus.stall) begin
          // hold everything
        end else if (state == HALT) begin
          do_bubble = 1'b1;
        end else if (bus.imem_inst == HALT_INST) begin
          state_nxt = HALT;
          do_bubble = 1'b1;
        end else begin
          pc_nxt  = pc_plus4;
          do_load = 1'b1;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_inst_q     <= NOP_INST;
      id_valid_q    <= 1'b0;
    end else if (do_load) begin
      id_pc_q       <= pc_q;
      id_pc_plus4_q <= pc_plus4;
      id_inst_q     <= bus.imem_inst;
      id_valid_q    <= 1'b1;
    end else if (do_bubble) begin
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      id_inst_q     <= NOP_INST;
      id_valid_q    <= 1'b0;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.id_inst     = id_inst_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.halted      = (state == HALT);

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  // Count IF/ID loads of real instructions and of bubbles; stalls count neither.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (do_load)   fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (do_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt  = fetch_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plus randomized checks of if_stage against a
// transaction-level fetch model.
module tb_if_stage;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [31:0] NOP_W  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] mem [64];

  if_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  if_stage #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000),
    .HALT_INST(HALT_W),
    .NOP_INST (NOP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_inst = mem[bus.imem_addr[7:2]];

  // Reference model: what the stage should hold after each edge.
  logic        m_boot, m_halt, m_valid;
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst;
  logic [31:0] m_fetch, m_bubble;

  task automatic model_reset();
    m_boot = 1'b1; m_halt = 1'b0; m_pc = 32'h0;
    m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_id_inst = NOP_W; m_valid = 1'b0;
    m_fetch = 32'h0; m_bubble = 32'h0;
  endtask

  task automatic model_bubble();
    m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_id_inst = NOP_W; m_valid = 1'b0;
    m_bubble = m_bubble + 32'd1;
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [31:0] rpc);
    logic [31:0] word;
    word = mem[m_pc[7:2]];
    if (m_boot) begin
      m_boot = 1'b0;
      if (rv) m_pc = rpc & 32'hFFFF_FFFC;
      model_bubble();
    end else if (rv) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_halt = 1'b0;
      model_bubble();
    end else if (st) begin
      // nothing moves
    end else if (m_halt) begin
      model_bubble();
    end else if (word == HALT_W) begin
      m_halt = 1'b1;
      model_bubble();
    end else begin
      m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_id_inst = word; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      m_fetch = m_fetch + 32'd1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"}, bus.imem_addr, m_pc);
    chk({tag, ".id_pc"}, bus.id_pc, m_id_pc);
    chk({tag, ".id_pc_plus4"}, bus.id_pc_plus4, m_id_pc4);
    chk({tag, ".id_inst"}, bus.id_inst, m_id_inst);
    chk({tag, ".id_valid"}, 32'(bus.id_valid), 32'(m_valid));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(m_halt));
`ifdef IF_PERF_CNT_EN
    chk({tag, ".fetch_cnt"}, bus.fetch_cnt, m_fetch);
    chk({tag, ".bubble_cnt"}, bus.bubble_cnt, m_bubble);
`endif
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input string tag, input logic st, input logic rv, input logic [31:0] rpc);
    bus.stall = st; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    #1;
    model_step(st, rv, rpc);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    for (int unsigned i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT_W) mem[i] = 32'h1234_5678;
    end
    mem[0] = 32'h2001_0005;
    mem[1] = 32'h2002_0007;
    mem[4] = HALT_W;
    model_reset();

    #3;
    check_all("reset");
    #5 rst = 1'b0;

    cycle("boot", 1'b0, 1'b0, 32'h0);
    chk("boot_valid", 32'(bus.id_valid), 32'h0);
    cycle("fetch0", 1'b0, 1'b0, 32'h0);
    chk("fetch0_inst", bus.id_inst, 32'h2001_0005);
    chk("fetch0_valid", 32'(bus.id_valid), 32'h1);
    cycle("fetch4", 1'b0, 1'b0, 32'h0);
    chk("fetch4_pc", bus.id_pc, 32'h4);
    chk("fetch4_pc4", bus.id_pc_plus4, 32'h8);
    for (int unsigned i = 0; i < 2; i++) begin
      cycle("stall", 1'b1, 1'b0, 32'h0);
      chk("stall_id_pc", bus.id_pc, 32'h4);
      chk("stall_addr", bus.imem_addr, 32'h8);
    end
    cycle("fetch8", 1'b0, 1'b0, 32'h0);
    chk("fetch8_pc", bus.id_pc, 32'h8);
    cycle("fetchC", 1'b0, 1'b0, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", bus.fetch_cnt, 32'd4);
    chk("perf_bubble", bus.bubble_cnt, 32'd1);
`endif
    for (int unsigned i = 0; i < 5; i++) begin
      cycle("halt", 1'b0, 1'b0, 32'h0);
      chk("halt_flag", 32'(bus.halted), 32'h1);
      chk("halt_addr", bus.imem_addr, 32'h10);
      chk("halt_valid", 32'(bus.id_valid), 32'h0);
    end
    cycle("halt_exit", 1'b0, 1'b1, 32'h20);
    chk("halt_exit_flag", 32'(bus.halted), 32'h0);
    cycle("after_exit", 1'b0, 1'b0, 32'h0);
    chk("after_exit_pc", bus.id_pc, 32'h20);
    cycle("redir_stall", 1'b1, 1'b1, 32'h0000_0043);
    chk("redir_valid", 32'(bus.id_valid), 32'h0);
    chk("redir_inst", bus.id_inst, 32'h0);
    chk("redir_addr", bus.imem_addr, 32'h40);
    cycle("after_redir", 1'b0, 1'b0, 32'h0);
    chk("after_redir_pc", bus.id_pc, 32'h40);
    cycle("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle("wrap", 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", bus.id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.id_pc_plus4, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst = 1'b0;

    // Randomized traffic with a few halt words planted.
    mem[20] = HALT_W;
    mem[45] = HALT_W;
    for (int unsigned i = 0; i < 400; i++) begin
      logic st, rv;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = 32'($urandom_range(0, 255));
      cycle("rand", st, rv, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
